// File: rtl/counter_scheduler.sv
// Round-robin scheduler sharing one external load/count counter between NUM_REQ requesters.
// Optional abort-on-request-drop behaviour is enabled with `define COUNTER_SCHED_ABORT_EN.
module counter_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_start,
    input  logic [NUM_REQ*WIDTH-1:0] req_limit,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [WIDTH-1:0]         cnt_data_in,
    output logic                     cnt_load,
    output logic                     cnt_count,
    input  logic [WIDTH-1:0]         cnt_value
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   data_in_q, data_in_d;
    logic               load_q, load_d;
    logic [WIDTH-1:0]   limit_q, limit_d;

    logic [WIDTH-1:0]   start_arr [NUM_REQ];
    logic [WIDTH-1:0]   limit_arr [NUM_REQ];
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand_idx;
    int unsigned        cand;
    logic               abort_c;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            start_arr[i] = req_start[i*WIDTH +: WIDTH];
            limit_arr[i] = req_limit[i*WIDTH +: WIDTH];
        end
    end

    // First set request at or above the rr pointer, wrapping around.
    always_comb begin
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            cand     = (32'(ptr_q) + k - 1) % NUM_REQ;
            cand_idx = PTR_W'(cand);
            if (req[cand_idx]) begin
                win_idx = cand_idx;
            end
        end
    end

`ifdef COUNTER_SCHED_ABORT_EN
    assign abort_c = ((state_q == LOAD) || (state_q == RUN)) && !req[win_q];
`else
    assign abort_c = 1'b0;
`endif

    // Counter advances until it reaches the latched terminal value.
    assign cnt_count = (state_q == RUN) && (cnt_value != limit_q) && !abort_c;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        busy_d    = busy_q;
        data_in_d = data_in_q;
        load_d    = 1'b0;
        limit_d   = limit_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d        = LOAD;
                    win_d          = win_idx;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    data_in_d      = start_arr[win_idx];
                    limit_d        = limit_arr[win_idx];
                    load_d         = 1'b1;
                    busy_d         = 1'b1;
                    ptr_d          = PTR_W'((32'(win_idx) + 32'd1) % NUM_REQ);
                end
            end
            LOAD: begin
                state_d = RUN;
            end
            RUN: begin
                if (cnt_value == limit_q) begin
                    state_d       = DONE;
                    done_d[win_q] = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase

        // A dropped request ends its interval silently; the counter keeps its value.
        if (abort_c) begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            data_in_q <= '0;
            load_q    <= 1'b0;
            limit_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            data_in_q <= data_in_d;
            load_q    <= load_d;
            limit_q   <= limit_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign cnt_data_in = data_in_q;
    assign cnt_load    = load_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Scoreboard bench for counter_scheduler: driver predicts each grant, a monitor checks whole intervals.
module tb_counter_scheduler;

    localparam int NR = 4;
    localparam int W  = 16;

`ifdef COUNTER_SCHED_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [NR-1:0]   req = '0;
    logic [NR*W-1:0] req_start = '0;
    logic [NR*W-1:0] req_limit = '0;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   done;
    logic            busy;
    logic [W-1:0]    cnt_data_in;
    logic            cnt_load;
    logic            cnt_count;
    logic [W-1:0]    cnt_value = '0;

    counter_scheduler #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .req_start   (req_start),
        .req_limit   (req_limit),
        .gnt         (gnt),
        .done        (done),
        .busy        (busy),
        .cnt_data_in (cnt_data_in),
        .cnt_load    (cnt_load),
        .cnt_count   (cnt_count),
        .cnt_value   (cnt_value)
    );

    always #5 clock = ~clock;

    // External load/count counter, never reset by the scheduler.
    always @(posedge clock) begin
        if (cnt_load)       cnt_value <= cnt_data_in;
        else if (cnt_count) cnt_value <= cnt_value + 16'd1;
    end

    typedef struct {
        int         idx;
        logic [W-1:0] start;
        logic [W-1:0] limit;
        bit         aborted;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] st [NR];
    logic [W-1:0] lm [NR];
    int           model_ptr = 0;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] r, input int p);
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (p + k) % NR;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    task automatic apply_vals();
        for (int i = 0; i < NR; i++) begin
            req_start[i*W +: W] = st[i];
            req_limit[i*W +: W] = lm[i];
        end
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 500; c++) begin
            @(posedge clock); #1;
            if (!busy) return;
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout: busy still high at %0t", $time);
    endtask

    // mode 0: normal, 1: drop request mid-RUN, 2: assert reset mid-RUN
    task automatic txn(input logic [NR-1:0] r, input int mode);
        exp_t         e;
        int           w;
        logic [W-1:0] stop_at;
        apply_vals();
        req = r;
        w = pick(r, model_ptr);
        e.idx     = w;
        e.start   = st[w];
        e.limit   = lm[w];
        e.aborted = (mode == 1) && ABORT_EN;
        exp_q.push_back(e);
        model_ptr = (w + 1) % NR;
        @(posedge clock); #1;
        chk("grant_latency_gnt", 32'(gnt), 32'(1 << w));
        chk("grant_latency_load", 32'(cnt_load), 32'd1);
        req_start = {$urandom(), $urandom()};
        req_limit = {$urandom(), $urandom()};
        if (mode == 0) begin
            req = NR'($urandom) | NR'(1 << w);
        end else begin
            stop_at = e.start + 16'd3;
            for (int c = 0; c < 100; c++) begin
                if (gnt != '0 && !cnt_load && cnt_value == stop_at) break;
                @(posedge clock); #1;
            end
            chk("mid_run_value", 32'(cnt_value), 32'(stop_at));
            if (mode == 1) begin
                req = '0;
                #1;
                chk("drop_cnt_count", 32'(cnt_count), ABORT_EN ? 32'd0 : 32'd1);
            end else begin
                reset = 1'b0;
                #1;
                chk("rst_gnt", 32'(gnt), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_load", 32'(cnt_load), 32'd0);
                chk("rst_count", 32'(cnt_count), 32'd0);
                chk("rst_data_in", 32'(cnt_data_in), 32'd0);
                exp_q.delete();
                model_ptr = 0;
                return;
            end
        end
        wait_idle();
    endtask

    // Monitor: tracks each grant from its first cycle to its release.
    exp_t          cur;
    bit            active = 1'b0;
    int            len, cnt_cyc, load_cyc, done_cnt, done_at;
    logic [NR-1:0] prev_gnt = '0;
    logic [W-1:0]  n_exp;

    always @(negedge clock) begin
        if (!reset) begin
            active   = 1'b0;
            prev_gnt = '0;
        end else begin
            chk("busy_vs_gnt", 32'(busy), 32'(|gnt));
            if (gnt != '0) begin
                if (!active) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant: gnt %0h with no prediction at %0t", gnt, $time);
                        cur.idx = 0; cur.start = '0; cur.limit = '0; cur.aborted = 1'b1;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    active = 1'b1;
                    len = 0; cnt_cyc = 0; load_cyc = 0; done_cnt = 0; done_at = 0;
                    chk("grant_onehot", 32'(gnt), 32'(1 << cur.idx));
                    chk("load_data", 32'(cnt_data_in), 32'(cur.start));
                end else begin
                    chk("grant_stable", 32'(gnt), 32'(prev_gnt));
                end
                len++;
                if (cnt_count) cnt_cyc++;
                if (cnt_load) load_cyc++;
                if (done != '0) begin
                    done_cnt++;
                    done_at = len;
                    chk("done_bit", 32'(done), 32'(1 << cur.idx));
                    chk("final_value", 32'(cnt_value), 32'(cur.limit));
                end
            end else begin
                chk("done_without_grant", 32'(done), 32'd0);
                if (active) begin
                    active = 1'b0;
                    n_exp  = cur.limit - cur.start;
                    if (cur.aborted) begin
                        chk("abort_no_done", 32'(done_cnt), 32'd0);
                    end else begin
                        chk("grant_len", 32'(len), 32'(n_exp) + 32'd3);
                        chk("count_cycles", 32'(cnt_cyc), 32'(n_exp));
                        chk("done_count", 32'(done_cnt), 32'd1);
                        chk("done_last_cycle", 32'(done_at), 32'(len));
                        chk("load_cycles", 32'(load_cyc), 32'd1);
                    end
                end
            end
            prev_gnt = gnt;
        end
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] r;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_load", 32'(cnt_load), 32'd0);
        chk("reset_count", 32'(cnt_count), 32'd0);
        chk("reset_data_in", 32'(cnt_data_in), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < NR; i++) begin st[i] = 16'h0000; lm[i] = 16'h0002; end
        repeat (5) txn(4'b1111, 0);

        st[0] = 16'h0000; lm[0] = 16'h0005;
        txn(4'b0001, 0);
        st[2] = 16'hFFFE; lm[2] = 16'h0001;
        txn(4'b0100, 0);
        st[3] = 16'h1234; lm[3] = 16'h1234;
        txn(4'b1000, 0);

        repeat (40) begin
            r = NR'($urandom_range(1, 15));
            for (int i = 0; i < NR; i++) begin
                st[i] = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                                    : 16'($urandom);
                lm[i] = st[i] + 16'($urandom_range(0, 12));
            end
            txn(r, 0);
        end

        repeat (6) begin
            r = NR'($urandom_range(1, 15));
            for (int i = 0; i < NR; i++) begin
                st[i] = 16'($urandom);
                lm[i] = st[i] + 16'($urandom_range(4, 12));
            end
            txn(r, 1);
        end

        st[0] = 16'h0000; lm[0] = 16'h000A;
        txn(4'b0001, 2);
        @(posedge clock); #1;
        reset = 1'b1;
        st[1] = 16'h0100; lm[1] = 16'h0104;
        txn(4'b0010, 0);

        st[1] = 16'h0000; lm[1] = 16'h0008;
        txn(4'b0010, 1);

        req = '0;
        repeat (5) @(posedge clock);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
